compress_arbiter: RTL and testbench
===================================

Name: compress_arbiter

Overview:
- Shares one EightDataCompressUnit datapath (8 x 32-bit words per beat, 2-bit tags, length output) between NUM_REQ requester streams.
- Grants are round-robin and burst-locked: a stream keeps the unit until its req_last beat, so per-stream compressor state is never interleaved.
- Drives the unit's wrtEn and data/tag inputs.
- Tracks in-flight beats through the unit's fixed pipeline, buffers results in an output FIFO tagged with requester ID, and applies credit-based flow control so the FIFO never overflows.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8)
- DATA_WIDTH, 32, bits per data word
- NUM_DATA, 8, words per beat
- TAG_WIDTH, 2, tag bits per word
- LEN_WIDTH, 8, compressed-length width
- CU_LATENCY, 2, cycles from cu_wrtEn high to valid cu_dataOut/cu_tagOut/cu_lenOut (>=1)
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accepted
- req_last  in  NUM_REQ  beat is last of burst
- req_data  in  NUM_REQ*DATA_WIDTH*NUM_DATA  raw beats, requester i at slice i
- req_cpr_data  in  NUM_REQ*DATA_WIDTH*NUM_DATA  compare data, sliced as req_data
- req_tag  in  NUM_REQ*TAG_WIDTH*NUM_DATA  input tags
- cu_wrtEn  out  1  write enable to compress unit
- cu_dataIn  out  DATA_WIDTH*NUM_DATA  to unit
- cu_cprDataIn  out  DATA_WIDTH*NUM_DATA  to unit
- cu_tagIn  out  TAG_WIDTH*NUM_DATA  to unit
- cu_dataOut  in  DATA_WIDTH*NUM_DATA  from unit
- cu_tagOut  in  TAG_WIDTH*NUM_DATA  from unit
- cu_lenOut  in  LEN_WIDTH  from unit
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_WIDTH*NUM_DATA  compressed data
- rsp_tag  out  TAG_WIDTH*NUM_DATA  output tags
- rsp_len  out  LEN_WIDTH  compressed length
- rsp_id  out  ID_W  originating requester, ID_W = max(1, clog2(NUM_REQ))
- rsp_last  out  1  last beat of burst

Behaviour:
- Reset (reset=0, async):
  - Outputs: req_ready=0, cu_wrtEn=0, cu_* data/tag=0, rsp_valid=0, rsp_* =0.
  - State: FSM=IDLE, rr_ptr=0, credits=FIFO_DEPTH, FIFO empty, latency pipe cleared.
  - Reset mid-burst drops all in-flight and buffered beats.
- FSM IDLE:
  - If any req_valid is high, grant the first index at or after rr_ptr (wrapping), latch it as gnt, go to GRANT.
  - No beat is accepted in the IDLE cycle, so there is one bubble per burst.
- FSM GRANT:
  - issue = req_valid[gnt] && credits!=0.
  - req_ready[gnt] = issue (combinational); all other req_ready bits are 0.
  - issue && req_last[gnt]: rr_ptr = (gnt+1) mod NUM_REQ, go to IDLE.
  - req_valid low or credits==0: remain in GRANT; the grant is never revoked mid-burst.
- Issue registers:
  - The cycle after issue: cu_wrtEn=1 and cu_dataIn/cu_cprDataIn/cu_tagIn carry the registered slice of gnt.
  - Otherwise cu_wrtEn=0 and the data registers hold their value.
- Latency pipe:
  - CU_LATENCY-stage shift register of {valid, id, last}, loaded with {cu_wrtEn, id, last} and shifted every cycle.
  - When the tail is valid, push {cu_dataOut, cu_tagOut, cu_lenOut, id, last} into the FIFO in that cycle.
  - Total latency: a beat accepted at cycle t appears at the FIFO head at t+1+CU_LATENCY+1 and is visible on rsp_* that cycle when the FIFO was empty.
- FIFO:
  - First-word-fall-through; rsp_valid = !empty.
  - Pop on rsp_valid && rsp_ready.
  - Pointers wrap mod FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- Credits:
  - Credits equal FIFO_DEPTH minus (in-flight beats + FIFO occupancy).
  - Decrement on issue, increment on pop; issue and pop in the same cycle leave credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go below 0.
  - Consequence: a push into a full FIFO is impossible.
- Assertions (simulation only):
  - No FIFO push while full.
  - No credit underflow or overflow.
  - At most one req_ready bit high.

Decomposition:
- Shared package cmp_pkg holds:
  - DATA_WIDTH, NUM_DATA, TAG_WIDTH, LEN_WIDTH constants (same values as the compressor defines).
  - BEAT_W = DATA_WIDTH*NUM_DATA, TAGS_W = TAG_WIDTH*NUM_DATA.
  - The arbiter state enum {IDLE, GRANT}.
- Sub-module cmp_rsp_fifo: parameterised FWFT FIFO (width, depth), instantiated once for the response path.

Test Plan:
- Single requester: req 0 sends a 3-beat burst with rsp_ready=1 and CU_LATENCY=2. Required: beats appear on rsp_* at t+4, t+5, t+6 with rsp_id=0 and rsp_last only on the third; cu_wrtEn high for 3 cycles.
- Round-robin: req 1 and req 3 both valid, each with 2-beat bursts, rr_ptr=0. Required: order is 1,1,3,3 with one bubble between bursts; rr_ptr then equals 0.
- Burst lock: req 0 holds valid low mid-burst for 5 cycles while req 2 is valid. Required: req_ready[2] stays 0 until req 0's last beat is accepted.
- Backpressure: rsp_ready=0 while 6 beats are offered with FIFO_DEPTH=4. Required: exactly 4 beats accepted, credits=0, FIFO full; after rsp_ready=1, the remaining 2 beats are accepted and there is no overflow.
- Simultaneous: pop and issue in the same cycle at credits=1. Required: credits stay 1 and data order is preserved.
- Reset mid-burst: assert reset with 2 beats in flight. Required: rsp_valid=0 immediately, credits=4, FSM in IDLE; post-reset arbitration starts at requester 0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants and types for the compress-unit arbiter and its response FIFO.
// Widths mirror the EightDataCompressUnit defines.
package cmp_pkg;

    localparam int CMP_DATA_WIDTH = 32;
    localparam int CMP_NUM_DATA   = 8;
    localparam int CMP_TAG_WIDTH  = 2;
    localparam int CMP_LEN_WIDTH  = 8;

    localparam int BEAT_W = CMP_DATA_WIDTH * CMP_NUM_DATA;
    localparam int TAGS_W = CMP_TAG_WIDTH * CMP_NUM_DATA;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_rsp_fifo.sv
// First-word-fall-through FIFO for compress-unit results.
// The head reads as zero while empty so the response bus is quiet when idle.
module cmp_rsp_fifo
    import cmp_pkg::*;
#(
    parameter int WIDTH = BEAT_W + TAGS_W + CMP_LEN_WIDTH + 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/compress_arbiter.sv
// Round-robin, burst-locked arbiter sharing one compress unit among NUM_REQ streams.
// Credits cover in-flight beats plus FIFO occupancy, so the response FIFO cannot overflow.
module compress_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = CMP_DATA_WIDTH,
    parameter int NUM_DATA   = CMP_NUM_DATA,
    parameter int TAG_WIDTH  = CMP_TAG_WIDTH,
    parameter int LEN_WIDTH  = CMP_LEN_WIDTH,
    parameter int CU_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int BW   = DATA_WIDTH * NUM_DATA,
    localparam int TW   = TAG_WIDTH * NUM_DATA,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*BW-1:0] req_data,
    input  logic [NUM_REQ*BW-1:0] req_cpr_data,
    input  logic [NUM_REQ*TW-1:0] req_tag,
    output logic                  cu_wrtEn,
    output logic [BW-1:0]         cu_dataIn,
    output logic [BW-1:0]         cu_cprDataIn,
    output logic [TW-1:0]         cu_tagIn,
    input  logic [BW-1:0]         cu_dataOut,
    input  logic [TW-1:0]         cu_tagOut,
    input  logic [LEN_WIDTH-1:0]  cu_lenOut,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BW-1:0]         rsp_data,
    output logic [TW-1:0]         rsp_tag,
    output logic [LEN_WIDTH-1:0]  rsp_len,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = BW + TW + LEN_WIDTH + ID_W + 1;

    arb_state_e      state_q;
    logic [ID_W-1:0] gnt_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] pick;
    logic            any_valid;
    logic [2*NUM_REQ-1:0] rot_valid;

    logic [CW-1:0]   credits_q;
    logic [CW-1:0]   credits_d;
    logic            issue;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    logic            wrt_q;
    logic [BW-1:0]   data_q;
    logic [BW-1:0]   cpr_q;
    logic [TW-1:0]   tag_q;
    logic [ID_W-1:0] id_q;
    logic            last_q;

    logic [CU_LATENCY-1:0]           pv_q;
    logic [CU_LATENCY-1:0][ID_W-1:0] pid_q;
    logic [CU_LATENCY-1:0]           plast_q;

    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Rotate so bit k is requester rr_ptr+k; the lowest set bit wins.
    assign rot_valid = {req_valid, req_valid} >> rr_ptr_q;

    always_comb begin
        pick      = rr_ptr_q;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick      = wrap_add(rr_ptr_q, k);
                any_valid = 1'b1;
            end
        end
    end

    assign issue     = (state_q == GRANT) && req_valid[gnt_q] && (credits_q != '0);
    assign req_ready = issue ? (NUM_REQ'(1) << gnt_q) : '0;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        gnt_q   <= pick;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (issue && req_last[gnt_q]) begin
                        rr_ptr_q <= wrap_add(gnt_q, 1);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrt_q  <= 1'b0;
            data_q <= '0;
            cpr_q  <= '0;
            tag_q  <= '0;
            id_q   <= '0;
            last_q <= 1'b0;
        end else begin
            wrt_q <= issue;
            if (issue) begin
                data_q <= req_data[gnt_q*BW +: BW];
                cpr_q  <= req_cpr_data[gnt_q*BW +: BW];
                tag_q  <= req_tag[gnt_q*TW +: TW];
                id_q   <= gnt_q;
                last_q <= req_last[gnt_q];
            end
        end
    end

    assign cu_wrtEn     = wrt_q;
    assign cu_dataIn    = data_q;
    assign cu_cprDataIn = cpr_q;
    assign cu_tagIn     = tag_q;

    // Sideband follows each beat through the unit's fixed latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q    <= '0;
            pid_q   <= '0;
            plast_q <= '0;
        end else begin
            pv_q[0]    <= wrt_q;
            pid_q[0]   <= id_q;
            plast_q[0] <= last_q;
            for (int i = 1; i < CU_LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pid_q[i]   <= pid_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (issue && !pop)      credits_d = credits_q - CW'(1);
        else if (pop && !issue) credits_d = credits_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) credits_q <= CW'(FIFO_DEPTH);
        else        credits_q <= credits_d;
    end

    assign fifo_din = {cu_dataOut, cu_tagOut, cu_lenOut, pid_q[CU_LATENCY-1], plast_q[CU_LATENCY-1]};

    cmp_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (pv_q[CU_LATENCY-1]),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign {rsp_data, rsp_tag, rsp_len, rsp_id, rsp_last} = fifo_dout;

    assert property (@(posedge clk) disable iff (!reset) !(issue && !pop && credits_q == '0));
    assert property (@(posedge clk) disable iff (!reset) !(pop && !issue && credits_q == CW'(FIFO_DEPTH)));
    assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));

endmodule

// File: tb/tb_compress_arbiter.sv
// Bench for compress_arbiter: a mock compress unit, a scoreboard fed from accepted
// beats, table-driven round-robin vectors, directed corner sequences and random traffic.
module tb_compress_arbiter;
    import cmp_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int ND  = 8;
    localparam int TWD = 2;
    localparam int LW  = 8;
    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int IDW = 2;
    localparam int BW  = DW * ND;
    localparam int TGW = TWD * ND;
    localparam int RW  = BW + TGW + LW + IDW + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, req_last;
    logic [NR*BW-1:0] req_data, req_cpr_data;
    logic [NR*TGW-1:0] req_tag;
    logic             cu_wrtEn;
    logic [BW-1:0]    cu_dataIn, cu_cprDataIn, cu_dataOut;
    logic [TGW-1:0]   cu_tagIn, cu_tagOut;
    logic [LW-1:0]    cu_lenOut;
    logic             rsp_valid, rsp_ready, rsp_last;
    logic [BW-1:0]    rsp_data;
    logic [TGW-1:0]   rsp_tag;
    logic [LW-1:0]    rsp_len;
    logic [IDW-1:0]   rsp_id;

    logic [BW-1:0]  rd [NR];
    logic [BW-1:0]  rc [NR];
    logic [TGW-1:0] rt [NR];
    logic [NR-1:0]  rv, rl;

    always_comb begin
        req_data     = '0;
        req_cpr_data = '0;
        req_tag      = '0;
        for (int i = 0; i < NR; i++) begin
            req_data[i*BW +: BW]     = rd[i];
            req_cpr_data[i*BW +: BW] = rc[i];
            req_tag[i*TGW +: TGW]    = rt[i];
        end
        req_valid = rv;
        req_last  = rl;
    end

    compress_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_DATA(ND), .TAG_WIDTH(TWD),
        .LEN_WIDTH(LW), .CU_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_data(req_data), .req_cpr_data(req_cpr_data), .req_tag(req_tag),
        .cu_wrtEn(cu_wrtEn), .cu_dataIn(cu_dataIn), .cu_cprDataIn(cu_cprDataIn),
        .cu_tagIn(cu_tagIn), .cu_dataOut(cu_dataOut), .cu_tagOut(cu_tagOut),
        .cu_lenOut(cu_lenOut), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_len(rsp_len),
        .rsp_id(rsp_id), .rsp_last(rsp_last)
    );

    // Mock compress unit: fixed latency, output is a simple function of the inputs.
    logic [BW-1:0]  hd [LAT];
    logic [BW-1:0]  hc [LAT];
    logic [TGW-1:0] ht [LAT];
    always @(posedge clk) begin
        hd[0] <= cu_dataIn;
        hc[0] <= cu_cprDataIn;
        ht[0] <= cu_tagIn;
        for (int i = 1; i < LAT; i++) begin
            hd[i] <= hd[i-1];
            hc[i] <= hc[i-1];
            ht[i] <= ht[i-1];
        end
    end
    assign cu_dataOut = hd[LAT-1] ^ hc[LAT-1];
    assign cu_tagOut  = ~ht[LAT-1];
    assign cu_lenOut  = hd[LAT-1][7:0] ^ 8'h5A;

    int nchk = 0;
    int npass = 0;
    int cyc = 0;
    int wrt_cnt = 0;
    int outst = 0;
    int lock = -1;
    bit abort = 1'b0;

    logic [RW-1:0] sb [$];
    int acc_id [$];
    int acc_cyc [$];
    int pop_id [$];
    int pop_cyc [$];
    int pop_last [$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] exp_rsp(input int i);
        return {rd[i] ^ rc[i], ~rt[i], rd[i][7:0] ^ 8'h5A, IDW'(i), rl[i]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: counts outstanding beats, tracks burst ownership, checks every pop.
    always @(negedge clk) begin
        int o;
        logic [RW-1:0] e;
        if (!reset) begin
            sb.delete();
            outst = 0;
            lock  = -1;
        end else begin
            chk("credits", dut.credits_q, FD - outst);
            chk("one_ready", $countones(req_ready) <= 1, 1);
            if (cu_wrtEn) wrt_cnt++;
            o = outst;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp", {rsp_data, rsp_tag, rsp_len, rsp_id, rsp_last}, e);
                end
                pop_id.push_back(int'(rsp_id));
                pop_cyc.push_back(cyc);
                pop_last.push_back(int'(rsp_last));
                outst--;
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    chk("accept_credit", o < FD, 1);
                    chk("burst_lock", (lock < 0) || (lock == i), 1);
                    lock = req_last[i] ? -1 : i;
                    sb.push_back(exp_rsp(i));
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                    outst++;
                end
            end
        end
    end

    task automatic clear_logs();
        acc_id.delete(); acc_cyc.delete();
        pop_id.delete(); pop_cyc.delete(); pop_last.delete();
    endtask

    task automatic send_beat(input int r, input bit last);
        bit ok;
        ok = 1'b0;
        rv[r] = 1'b1;
        rl[r] = last;
        for (int w = 0; w < ND; w++) begin
            rd[r][w*DW +: DW] = $urandom;
            rc[r][w*DW +: DW] = $urandom;
        end
        rt[r] = TGW'($urandom);
        for (int k = 0; k < 400 && !abort; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!abort) chk("beat_handshake", ok, 1);
        @(posedge clk);
        #1;
        rv[r] = 1'b0;
        rl[r] = 1'b0;
    endtask

    task automatic send_burst(input int r, input int n, input int gap_idx, input int gap_len);
        for (int b = 0; b < n; b++) begin
            if (abort) break;
            send_beat(r, b == n - 1);
            if (b == gap_idx && b != n - 1 && gap_len > 0) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid && dut.credits_q == FD) break;
        end
        chk("drain", k < 300, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic rand_stream(input int r);
        int n;
        repeat (10) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            n = $urandom_range(1, 4);
            send_burst(r, n, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_rdy;
    } rr_vec_t;

    rr_vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        int k;
        int w0;

        tbl[0] = '{4'b1010, 4'b0010};
        tbl[1] = '{4'b1010, 4'b1000};
        tbl[2] = '{4'b0001, 4'b0001};
        tbl[3] = '{4'b0001, 4'b0001};
        tbl[4] = '{4'b1111, 4'b0010};
        tbl[5] = '{4'b1111, 4'b0100};
        tbl[6] = '{4'b0111, 4'b0001};
        tbl[7] = '{4'b1000, 4'b1000};

        for (int i = 0; i < NR; i++) begin
            rd[i] = '0; rc[i] = '0; rt[i] = '0;
        end
        rv = '0;
        rl = '0;
        rsp_ready = 1'b0;
        reset = 1'b0;

        // Reset state with a requester already valid.
        rv[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cu_wrtEn", cu_wrtEn, 0);
        chk("rst_cu_dataIn", cu_dataIn, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_credits", dut.credits_q, FD);
        chk("rst_rr_ptr", dut.rr_ptr_q, 0);
        rv[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: single-beat bursts exercise the round-robin pointer.
        rsp_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NR; i++) begin
                rv[i] = tbl[t].mask[i];
                rl[i] = 1'b1;
                rd[i] = {8{32'(t * 16 + i)}};
                rc[i] = {8{32'h0F0F_0000 + 32'(i)}};
                rt[i] = TGW'(t + i);
            end
            for (k = 0; k < 10; k++) begin
                @(negedge clk);
                if (|req_ready) break;
            end
            chk("rr_table", req_ready, tbl[t].exp_rdy);
            @(posedge clk);
            #1;
            rv = '0;
            rl = '0;
        end
        wait_drain();

        // Single requester, 3-beat burst: latency and framing.
        do_reset();
        rsp_ready = 1'b1;
        clear_logs();
        w0 = wrt_cnt;
        send_burst(0, 3, -1, 0);
        wait_drain();
        chk("single_acc_n", acc_id.size(), 3);
        chk("single_pop_n", pop_id.size(), 3);
        chk("single_back2back", acc_cyc[2] - acc_cyc[0], 2);
        for (int i = 0; i < 3; i++) begin
            chk("single_latency", pop_cyc[i] - acc_cyc[i], LAT + 2);
            chk("single_id", pop_id[i], 0);
            chk("single_last", pop_last[i], i == 2);
        end
        chk("single_wrtEn_cycles", wrt_cnt - w0, 3);

        // Round-robin between requesters 1 and 3 from rr_ptr 0.
        do_reset();
        clear_logs();
        fork
            send_burst(1, 2, -1, 0);
            send_burst(3, 2, -1, 0);
        join
        wait_drain();
        chk("rr_acc_n", acc_id.size(), 4);
        chk("rr_order0", acc_id[0], 1);
        chk("rr_order1", acc_id[1], 1);
        chk("rr_order2", acc_id[2], 3);
        chk("rr_order3", acc_id[3], 3);
        chk("rr_gap01", acc_cyc[1] - acc_cyc[0], 1);
        chk("rr_bubble", acc_cyc[2] - acc_cyc[1], 2);
        chk("rr_gap23", acc_cyc[3] - acc_cyc[2], 1);
        chk("rr_ptr_after", dut.rr_ptr_q, 0);

        // Burst lock: requester 0 stalls mid-burst while requester 2 waits.
        do_reset();
        clear_logs();
        fork
            send_burst(0, 2, 0, 5);
            send_burst(2, 1, -1, 0);
        join
        wait_drain();
        chk("lock_acc_n", acc_id.size(), 3);
        chk("lock_order0", acc_id[0], 0);
        chk("lock_order1", acc_id[1], 0);
        chk("lock_order2", acc_id[2], 2);
        chk("lock_stall_held", acc_cyc[1] - acc_cyc[0] >= 6, 1);
        chk("lock_req2_after_last", acc_cyc[2] - acc_cyc[1], 2);

        // Backpressure: 6 beats offered into a 4-deep FIFO with no consumer.
        do_reset();
        clear_logs();
        rsp_ready = 1'b0;
        fork
            send_burst(0, 6, -1, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("bp_accepted", acc_id.size(), 4);
                chk("bp_credits", dut.credits_q, 0);
                chk("bp_fifo_full", dut.fifo_full, 1);
                chk("bp_rsp_valid", rsp_valid, 1);
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_total", acc_id.size(), 6);
        chk("bp_popped", pop_id.size(), 6);

        // Pop and issue in the same cycle with one credit left.
        do_reset();
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("sim_credits_before", dut.credits_q, 1);
        chk("sim_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        send_beat(0, 1'b0);
        chk("sim_credits_after", dut.credits_q, 1);
        send_beat(0, 1'b1);
        wait_drain();
        chk("sim_popped", pop_id.size(), 5);

        // Reset mid-burst after moving rr_ptr to 2.
        do_reset();
        rsp_ready = 1'b1;
        send_burst(1, 1, -1, 0);
        wait_drain();
        chk("rst_pre_rr_ptr", dut.rr_ptr_q, 2);
        clear_logs();
        fork
            send_burst(2, 4, -1, 0);
            begin
                for (k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (acc_id.size() >= 2) break;
                end
                chk("rst_mid_reached", k < 100, 1);
                @(posedge clk);
                #3;
                reset = 1'b0;
                abort = 1'b1;
                #1;
                chk("rst_mid_rsp_valid", rsp_valid, 0);
                chk("rst_mid_credits", dut.credits_q, FD);
                chk("rst_mid_state", dut.state_q, IDLE);
                chk("rst_mid_rr_ptr", dut.rr_ptr_q, 0);
                chk("rst_mid_wrtEn", cu_wrtEn, 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
            end
        join
        abort = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        fork
            send_burst(0, 1, -1, 0);
            send_burst(3, 1, -1, 0);
        join
        wait_drain();
        chk("rst_post_first", acc_id[0], 0);
        chk("rst_post_second", acc_id[1], 3);

        // Random traffic from all requesters with a stuttering consumer.
        do_reset();
        clear_logs();
        done_cnt = 0;
        fork
            begin rand_stream(0); done_cnt++; end
            begin rand_stream(1); done_cnt++; end
            begin rand_stream(2); done_cnt++; end
            begin rand_stream(3); done_cnt++; end
            begin
                while (done_cnt < 4) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
        chk("rand_all_popped", pop_id.size(), acc_id.size());

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
